pkt_stream_buf: RTL and testbench
=================================

Name: pkt_stream_buf

Overview:
- Parametrised successor of the 8-bit din/len/dout/cfg streaming block.
- Buffers data words in a DEPTH-deep data FIFO and packet lengths in an LDEPTH-deep length FIFO.
- Emits data on dout in whole packets, one length entry per packet.
- Adds a 32-bit cfg register map for enable, flush, status and statistics counters. Sits between a byte/word producer and a packet-oriented consumer.

Parameters:
DW, 8, data word width (din_value/dout_value)
DEPTH, 16, data FIFO entries (power of 2, >=2)
LW, 8, packet length width (len_value)
LDEPTH, 4, length FIFO entries (power of 2, >=2)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
din_value  input  DW  data word in
din_en  input  1  push din_value (valid only when din_rdy=1)
din_rdy  output  1  data FIFO not full
dout_en  input  1  pop current dout_value (valid only when dout_rdy=1)
dout_value  output  DW  head of data FIFO (0 when dout_rdy=0)
dout_rdy  output  1  word of current packet available
len_value  input  LW  packet length in words
len_en  input  1  push len_value (valid only when len_rdy=1)
len_rdy  output  1  length FIFO not full
cfg_address  input  8  register index
cfg_data_in  input  32  write data
cfg_op  input  1  1=write, 0=read
cfg_en  input  1  cfg access strobe
cfg_data_out  output  32  read data, combinational from cfg_address
cfg_rdy  output  1  1 whenever out of reset

Behaviour:
- Reset: RST_N low clears both FIFOs, FSM=IDLE and all counters asynchronously. CTRL.enable=1. All outputs 0 while in reset (din_rdy, len_rdy, dout_rdy, cfg_rdy, dout_value, cfg_data_out).
- Handshake: every *_en with its *_rdy low is ignored. Push, pop and cfg write take effect at the clock edge where en=1.
- Data FIFO: din_rdy = count<DEPTH.
  - A push into an empty FIFO is visible on dout no earlier than the next cycle.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo DEPTH.
- Length FIFO: len_rdy = lcount<LDEPTH. Pointers wrap modulo LDEPTH.
- Output FSM:
  - IDLE: if CTRL.enable and lcount>0, pop the length entry.
    - len==0: ZERO_CNT++ and remain IDLE.
    - Otherwise: remaining<=len and go to STREAM.
  - STREAM: dout_rdy = (count>0). Each dout_en pops one word and decrements remaining.
    - A pop with remaining==1 increments PKT_CNT and returns to IDLE.
    - Minimum gap between packets is one IDLE cycle.
  - In IDLE, dout_rdy=0.
- Enable: CTRL.enable=0 blocks IDLE->STREAM only. A packet already in STREAM completes. Pushes are still accepted.
- Flush: writing CTRL bit1=1 empties both FIFOs and forces FSM=IDLE at that edge.
  - Counters are retained; bit1 reads 0.
  - A din/len push in the same cycle as the flush is discarded.
- Register map (index on cfg_address):
  - 0x00 CTRL: [0] enable RW, [1] flush W1, others 0.
  - 0x01 STATUS RO: [15:0] data count, [23:16] length count, [24] FSM in STREAM, [25] data full, [26] length full.
  - 0x02 PKT_CNT: completed packets, wraps 2^32-1->0. Any write clears it.
  - 0x03 ZERO_CNT: discarded zero-length entries. Any write clears it.
  - Other addresses read 0; writes to them are ignored.
- Counter increment and clear in the same cycle: clear wins.
- Reads are combinational and side-effect free. cfg_en is required only for writes.

Test Plan:
- Reset, then push len=3 and din 0x11,0x22,0x33, hold dout_en=1 -> dout_value 0x11,0x22,0x33 on 3 consecutive accepted pops, dout_rdy=0 afterwards, PKT_CNT=1.
- Push DEPTH=16 words with no length -> din_rdy=0 after the 16th push, STATUS[15:0]=16, STATUS[25]=1. Push len=16 and drain -> all 16 words in order, din_rdy re-asserts after the first pop.
- Push len=0 then len=2 with 2 words -> ZERO_CNT=1, one 2-word packet out, PKT_CNT=1.
- Write CTRL=0, push len=2 with 2 words -> dout_rdy stays 0. Write CTRL=1 -> packet streams out.
- Stream len=4 with 2 words pushed, then write CTRL=0x3 mid-packet -> STATUS=0, FSM IDLE, dout_rdy=0, PKT_CNT unchanged, CTRL reads 0x1.
- Assert RST_N low mid-packet -> all outputs 0 immediately. After release CTRL reads 1, PKT_CNT=0, din_rdy=len_rdy=cfg_rdy=1.

Source files
------------

// File: rtl/pkt_stream_buf.sv
// pkt_stream_buf -- packet-oriented stream buffer.
//
// Data words are queued in a DEPTH-entry FIFO and packet lengths in an
// LDEPTH-entry FIFO. An output FSM takes one length entry at a time and
// releases exactly that many words on dout before taking the next one.
// A 32-bit register map provides enable, flush, status and statistics.
//
// Ports:
//   CLK, RST_N               clock (rising edge), async active-low reset
//   din_value/din_en/din_rdy  data word push handshake
//   len_value/len_en/len_rdy  packet length push handshake
//   dout_value/dout_en/dout_rdy  word pop handshake (value 0 when not ready)
//   cfg_address/cfg_data_in/cfg_op/cfg_en  register access (op=1 write)
//   cfg_data_out              combinational read data for cfg_address
//   cfg_rdy                   high whenever out of reset
module pkt_stream_buf #(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int LW     = 8,
  parameter int LDEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] din_value,
  input  logic          din_en,
  output logic          din_rdy,
  input  logic          dout_en,
  output logic [DW-1:0] dout_value,
  output logic          dout_rdy,
  input  logic [LW-1:0] len_value,
  input  logic          len_en,
  output logic          len_rdy,
  input  logic [7:0]    cfg_address,
  input  logic [31:0]   cfg_data_in,
  input  logic          cfg_op,
  input  logic          cfg_en,
  output logic [31:0]   cfg_data_out,
  output logic          cfg_rdy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LAW = $clog2(LDEPTH);

  typedef enum logic {IDLE, STREAM} state_e;

  logic [DW-1:0] mem_q  [DEPTH];
  logic [LW-1:0] lmem_q [LDEPTH];

  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    count_q, count_d;
  logic [LAW-1:0] lwptr_q, lwptr_d, lrptr_q, lrptr_d;
  logic [LAW:0]   lcount_q, lcount_d;

  state_e        state_q;
  logic [LW-1:0] remaining_q;
  logic          enable_q;
  logic [31:0]   pkt_cnt_q, zero_cnt_q;

  logic cfg_wr, flush, push, pop, lpush, lpop;
  logic full, lfull, pkt_done;
  logic [LW-1:0] len_head;
  logic [31:0] status;

  // Only CTRL uses write data; counter writes clear regardless of value.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_data_in[31:2];

  // Counts never exceed the (power-of-2) depth, so the MSB alone means full.
  assign full  = count_q[AW];
  assign lfull = lcount_q[LAW];

  assign cfg_rdy = RST_N;
  assign cfg_wr  = cfg_en & cfg_op & RST_N;
  assign flush   = cfg_wr & (cfg_address == 8'h00) & cfg_data_in[1];

  assign din_rdy  = RST_N & ~full;
  assign len_rdy  = RST_N & ~lfull;
  assign dout_rdy = RST_N & (state_q == STREAM) & (count_q != '0);

  // A flush wins over any push or pop arriving in the same cycle.
  assign push  = din_en & din_rdy & ~flush;
  assign lpush = len_en & len_rdy & ~flush;
  assign pop   = dout_en & dout_rdy & ~flush;
  assign lpop  = RST_N & (state_q == IDLE) & enable_q & (lcount_q != '0) & ~flush;

  assign pkt_done   = pop & (remaining_q == LW'(1));
  assign len_head   = lmem_q[lrptr_q];
  assign dout_value = dout_rdy ? mem_q[rptr_q] : '0;

  assign status = {5'b0, lfull, full, (state_q == STREAM),
                   8'(lcount_q), 16'(count_q)};

  always_comb begin
    cfg_data_out = '0;
    if (RST_N) begin
      case (cfg_address)
        8'h00:   cfg_data_out = {31'b0, enable_q};
        8'h01:   cfg_data_out = status;
        8'h02:   cfg_data_out = pkt_cnt_q;
        8'h03:   cfg_data_out = zero_cnt_q;
        default: cfg_data_out = '0;
      endcase
    end
  end

  // FIFO pointer/count next state.
  always_comb begin
    wptr_d   = wptr_q + AW'(push);
    rptr_d   = rptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    lwptr_d  = lwptr_q + LAW'(lpush);
    lrptr_d  = lrptr_q + LAW'(lpop);
    lcount_d = lcount_q + (LAW+1)'(lpush) - (LAW+1)'(lpop);
    if (flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      lwptr_d  = '0;
      lrptr_d  = '0;
      lcount_d = '0;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counts.
  always_ff @(posedge CLK) begin
    if (push)  mem_q[wptr_q]   <= din_value;
    if (lpush) lmem_q[lwptr_q] <= len_value;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      lwptr_q     <= '0;
      lrptr_q     <= '0;
      lcount_q    <= '0;
      state_q     <= IDLE;
      remaining_q <= '0;
      enable_q    <= 1'b1;
      pkt_cnt_q   <= '0;
      zero_cnt_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      lwptr_q  <= lwptr_d;
      lrptr_q  <= lrptr_d;
      lcount_q <= lcount_d;

      if (cfg_wr && cfg_address == 8'h00) enable_q <= cfg_data_in[0];

      // Output FSM
      if (flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (lpop && len_head != '0) begin
            remaining_q <= len_head;
            state_q     <= STREAM;
          end
          STREAM: if (pop) begin
            remaining_q <= remaining_q - LW'(1);
            if (remaining_q == LW'(1)) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end

      // Statistics: a clearing write beats a same-cycle increment.
      if (cfg_wr && cfg_address == 8'h02) pkt_cnt_q <= '0;
      else if (pkt_done)                  pkt_cnt_q <= pkt_cnt_q + 32'd1;

      if (cfg_wr && cfg_address == 8'h03)  zero_cnt_q <= '0;
      else if (lpop && len_head == '0)     zero_cnt_q <= zero_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_pkt_stream_buf.sv
// Directed, table-driven bench for pkt_stream_buf (default parameters).
// Each vector drives inputs at the falling edge, checks outputs 1 time unit
// later (before the rising edge that commits the inputs).
module tb_pkt_stream_buf;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  din_value, len_value, dout_value, cfg_address;
  logic        din_en, din_rdy, dout_en, dout_rdy, len_en, len_rdy;
  logic [31:0] cfg_data_in, cfg_data_out;
  logic        cfg_op, cfg_en, cfg_rdy;

  pkt_stream_buf dut (
    .CLK(CLK), .RST_N(RST_N),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        din_en;
    logic [7:0]  din;
    logic        len_en;
    logic [7:0]  len;
    logic        dout_en;
    logic        cfg_en;
    logic        cfg_op;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        e_din_rdy;
    logic        e_len_rdy;
    logic        e_dout_rdy;
    logic [7:0]  e_dout;
    logic [31:0] e_cfg;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t V(logic de, logic [7:0] d, logic le, logic [7:0] l,
                             logic oe, logic ce, logic co, logic [7:0] a,
                             logic [31:0] w, logic edr, logic elr, logic eor,
                             logic [7:0] eo, logic [31:0] ec);
    vec_t v;
    v.din_en = de; v.din = d; v.len_en = le; v.len = l; v.dout_en = oe;
    v.cfg_en = ce; v.cfg_op = co; v.addr = a; v.wdata = w;
    v.e_din_rdy = edr; v.e_len_rdy = elr; v.e_dout_rdy = eor;
    v.e_dout = eo; v.e_cfg = ec;
    return v;
  endfunction

  // STATUS word from its fields.
  function automatic logic [31:0] S(int cnt, int lcnt, bit strm, bit f, bit lf);
    return {5'b0, lf, f, strm, 8'(lcnt), 16'(cnt)};
  endfunction

  task automatic cmp(int id, string what, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %h expected %h", id, what, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge CLK);
    din_en = v.din_en; din_value = v.din; len_en = v.len_en; len_value = v.len;
    dout_en = v.dout_en; cfg_en = v.cfg_en; cfg_op = v.cfg_op;
    cfg_address = v.addr; cfg_data_in = v.wdata;
    #1;
    cmp(n_vec, "din_rdy", 32'(din_rdy), 32'(v.e_din_rdy));
    cmp(n_vec, "len_rdy", 32'(len_rdy), 32'(v.e_len_rdy));
    cmp(n_vec, "dout_rdy", 32'(dout_rdy), 32'(v.e_dout_rdy));
    cmp(n_vec, "dout_value", 32'(dout_value), 32'(v.e_dout));
    cmp(n_vec, "cfg_rdy", 32'(cfg_rdy), 32'd1);
    cmp(n_vec, "cfg_data_out", cfg_data_out, v.e_cfg);
    $display("vec %0d: din_en=%0d len_en=%0d dout_en=%0d cfg_en=%0d addr=%h dout=%h cfg=%h",
             n_vec, v.din_en, v.len_en, v.dout_en, v.cfg_en, v.addr, dout_value, cfg_data_out);
    n_vec++;
  endtask

  task automatic check_reset_outputs();
    cmp(n_vec, "rst din_rdy", 32'(din_rdy), 0);
    cmp(n_vec, "rst len_rdy", 32'(len_rdy), 0);
    cmp(n_vec, "rst dout_rdy", 32'(dout_rdy), 0);
    cmp(n_vec, "rst cfg_rdy", 32'(cfg_rdy), 0);
    cmp(n_vec, "rst dout_value", 32'(dout_value), 0);
    cmp(n_vec, "rst cfg_data_out", cfg_data_out, 0);
    $display("vec %0d: reset asserted, outputs checked", n_vec);
    n_vec++;
  endtask

  initial begin
    RST_N = 1'b0;
    din_en = 0; din_value = 0; len_en = 0; len_value = 0; dout_en = 0;
    cfg_en = 0; cfg_op = 0; cfg_address = 8'h00; cfg_data_in = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    check_reset_outputs();
    @(negedge CLK); RST_N = 1'b1;

    // ---- 1: basic 3-word packet
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h00,0, 1,1,0,0,    32'd1));
    tbl.push_back(V(1,8'h11,1,3, 0, 0,0,8'h01,0, 1,1,0,0,    S(0,0,0,0,0)));
    tbl.push_back(V(1,8'h22,0,0, 0, 0,0,8'h01,0, 1,1,0,0,    S(1,1,0,0,0)));
    tbl.push_back(V(1,8'h33,0,0, 1, 0,0,8'h01,0, 1,1,1,8'h11,S(2,0,1,0,0)));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h01,0, 1,1,1,8'h22,S(2,0,1,0,0)));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h01,0, 1,1,1,8'h33,S(1,0,1,0,0)));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h02,0, 1,1,0,0,    32'd1));
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h01,0, 1,1,0,0,    S(0,0,0,0,0)));

    // ---- 2: fill the data FIFO, then drain as one 16-word packet
    for (int i = 0; i < 16; i++)
      tbl.push_back(V(1,8'(8'hA0+i),0,0, 0, 0,0,8'h01,0, 1,1,0,0, S(i,0,0,0,0)));
    tbl.push_back(V(1,8'hFF,0,0,  0, 0,0,8'h01,0, 0,1,0,0, S(16,0,0,1,0)));
    tbl.push_back(V(0,0,    1,16, 0, 0,0,8'h01,0, 0,1,0,0, S(16,0,0,1,0)));
    tbl.push_back(V(0,0,    0,0,  0, 0,0,8'h01,0, 0,1,0,0, S(16,1,0,1,0)));
    for (int i = 0; i < 16; i++)
      tbl.push_back(V(0,0,0,0, 1, 0,0,8'h01,0, (i != 0),1,1,8'(8'hA0+i),
                      S(16-i,0,1,(i == 0),0)));
    tbl.push_back(V(0,0,0,0, 0, 0,0,8'h02,0, 1,1,0,0, 32'd2));

    // ---- 3: zero-length entry then a 2-word packet (PKT_CNT cleared first)
    tbl.push_back(V(0,0,    0,0, 0, 1,1,8'h02,32'hDEAD, 1,1,0,0, 32'd2));
    tbl.push_back(V(0,0,    1,0, 0, 0,0,8'h02,0, 1,1,0,0,    32'd0));
    tbl.push_back(V(1,8'h51,1,2, 0, 0,0,8'h03,0, 1,1,0,0,    32'd0));
    tbl.push_back(V(1,8'h52,0,0, 0, 0,0,8'h03,0, 1,1,0,0,    32'd1));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h02,0, 1,1,1,8'h51,32'd0));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h02,0, 1,1,1,8'h52,32'd0));
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h02,0, 1,1,0,0,    32'd1));

    // ---- 4: disabled output holds a queued packet until re-enabled
    tbl.push_back(V(0,0,    0,0, 0, 1,1,8'h00,32'h0, 1,1,0,0, 32'd1));
    tbl.push_back(V(1,8'h61,1,2, 0, 0,0,8'h00,0, 1,1,0,0,    32'd0));
    tbl.push_back(V(1,8'h62,0,0, 0, 0,0,8'h00,0, 1,1,0,0,    32'd0));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h01,0, 1,1,0,0,    S(2,1,0,0,0)));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h01,0, 1,1,0,0,    S(2,1,0,0,0)));
    tbl.push_back(V(0,0,    0,0, 0, 1,1,8'h00,32'h1, 1,1,0,0, 32'd0));
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h00,0, 1,1,0,0,    32'd1));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h01,0, 1,1,1,8'h61,S(2,0,1,0,0)));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h01,0, 1,1,1,8'h62,S(1,0,1,0,0)));
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h02,0, 1,1,0,0,    32'd2));

    // ---- 5: flush mid-packet; same-cycle pushes are discarded
    tbl.push_back(V(1,8'h71,1,4, 0, 0,0,8'h01,0, 1,1,0,0,    S(0,0,0,0,0)));
    tbl.push_back(V(1,8'h72,0,0, 0, 0,0,8'h01,0, 1,1,0,0,    S(1,1,0,0,0)));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h01,0, 1,1,1,8'h71,S(2,0,1,0,0)));
    tbl.push_back(V(1,8'h73,1,5, 0, 1,1,8'h00,32'h3, 1,1,1,8'h72, 32'd1));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h01,0, 1,1,0,0,    S(0,0,0,0,0)));
    tbl.push_back(V(0,0,    0,0, 1, 0,0,8'h00,0, 1,1,0,0,    32'd1));
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h02,0, 1,1,0,0,    32'd2));
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h03,0, 1,1,0,0,    32'd1));
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h01,0, 1,1,0,0,    S(0,0,0,0,0)));
    // unmapped address reads 0 and ignores writes
    tbl.push_back(V(0,0,    0,0, 0, 1,1,8'h07,32'hFFFF, 1,1,0,0, 32'd0));
    tbl.push_back(V(0,0,    0,0, 0, 0,0,8'h00,0, 1,1,0,0,    32'd1));

    foreach (tbl[i]) apply(tbl[i]);

    // ---- 6: asynchronous reset in the middle of a packet
    apply(V(1,8'h81,1,3, 0, 0,0,8'h00,0, 1,1,0,0,    32'd1));
    apply(V(1,8'h82,0,0, 0, 0,0,8'h00,0, 1,1,0,0,    32'd1));
    apply(V(0,0,    0,0, 0, 0,0,8'h00,0, 1,1,1,8'h81,32'd1));
    @(negedge CLK);
    din_en = 0; len_en = 0; dout_en = 1; cfg_en = 0; cfg_address = 8'h00;
    #2 RST_N = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge CLK); RST_N = 1'b1; dout_en = 0;
    apply(V(0,0,0,0, 0, 0,0,8'h00,0, 1,1,0,0, 32'd1));
    apply(V(0,0,0,0, 0, 0,0,8'h02,0, 1,1,0,0, 32'd0));
    apply(V(0,0,0,0, 0, 0,0,8'h03,0, 1,1,0,0, 32'd0));
    apply(V(0,0,0,0, 1, 0,0,8'h01,0, 1,1,0,0, S(0,0,0,0,0)));

    // ---- 7: length FIFO full boundary, then flush with enable restored
    apply(V(0,0,0,0, 0, 1,1,8'h00,32'h0, 1,1,0,0, 32'd1));
    for (int i = 0; i < 4; i++)
      apply(V(0,0,1,0, 0, 0,0,8'h01,0, 1,1,0,0, S(0,i,0,0,0)));
    apply(V(0,0,1,7, 0, 0,0,8'h01,0, 1,0,0,0, S(0,4,0,0,1)));
    apply(V(0,0,0,0, 0, 1,1,8'h00,32'h3, 1,0,0,0, 32'd0));
    apply(V(0,0,0,0, 0, 0,0,8'h01,0, 1,1,0,0, S(0,0,0,0,0)));
    apply(V(0,0,0,0, 0, 0,0,8'h00,0, 1,1,0,0, 32'd1));
    apply(V(0,0,0,0, 0, 0,0,8'h03,0, 1,1,0,0, 32'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
